// File: rtl/timer_alarm.sv
// CPU-programmable alarm on the free-running timer tick count: one-shot or periodic
// deadline, sticky fired flag with maskable IRQ, and a tear-free counter snapshot.
module timer_alarm #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COUNTER_WIDTH-1:0] counter,
    input  logic [2:0]               addr,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic                     irq
);

    localparam logic [2:0] ADDR_INT_LO = 3'd0;
    localparam logic [2:0] ADDR_INT_HI = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STAT   = 3'd3;
    localparam logic [2:0] ADDR_CNT_LO = 3'd4;
    localparam logic [2:0] ADDR_CNT_HI = 3'd5;

    logic [COUNTER_WIDTH-1:0] interval_q, interval_d;
    logic [COUNTER_WIDTH-1:0] deadline_q, deadline_d;
    logic                     enable_q, enable_d;
    logic                     periodic_q, periodic_d;
    logic                     irq_en_q, irq_en_d;
    logic                     fired_q, fired_d;
    logic [7:0]               snap_hi_q, snap_hi_d;
    logic [7:0]               data_out_q, data_out_d;
    logic [7:0]               read_data;
    logic                     match;

    always_comb begin
        read_data = 8'h00;
        case (addr)
            ADDR_INT_LO: read_data = interval_q[7:0];
            ADDR_INT_HI: read_data = interval_q[15:8];
            ADDR_CTRL:   read_data = {5'b00000, irq_en_q, periodic_q, enable_q};
            ADDR_STAT:   read_data = {7'b0000000, fired_q};
            ADDR_CNT_LO: read_data = counter[7:0];
            ADDR_CNT_HI: read_data = snap_hi_q;
            default:     read_data = 8'h00;
        endcase
    end

    assign match = enable_q && (counter == deadline_q);

    always_comb begin
        interval_d = interval_q;
        deadline_d = deadline_q;
        enable_d   = enable_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        fired_d    = fired_q;
        snap_hi_d  = snap_hi_q;
        data_out_d = data_out_q;

        if (match) begin
            fired_d = 1'b1;
            if (periodic_q) begin
                deadline_d = deadline_q + interval_q;
            end else begin
                enable_d = 1'b0;
            end
        end

        // A CTRL write overrides the fire's enable/deadline update, so a same-clk arm proceeds.
        if (wr) begin
            case (addr)
                ADDR_INT_LO: interval_d[7:0]  = data_in;
                ADDR_INT_HI: interval_d[15:8] = data_in;
                ADDR_CTRL: begin
                    periodic_d = data_in[1];
                    irq_en_d   = data_in[2];
                    if (data_in[0] && (interval_q != '0)) begin
                        enable_d   = 1'b1;
                        deadline_d = counter + interval_q;
                    end else begin
                        enable_d = 1'b0;
                    end
                end
                ADDR_STAT: begin
                    if (data_in[0] && !match) begin
                        fired_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (rd) begin
            data_out_d = read_data;
            if (addr == ADDR_CNT_LO) begin
                snap_hi_d = counter[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            interval_q <= '0;
            deadline_q <= '0;
            enable_q   <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            fired_q    <= 1'b0;
            snap_hi_q  <= 8'h00;
            data_out_q <= 8'h00;
        end else begin
            interval_q <= interval_d;
            deadline_q <= deadline_d;
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            fired_q    <= fired_d;
            snap_hi_q  <= snap_hi_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = fired_q & irq_en_q;

endmodule
